// File: rtl/mpu_temp_filter.sv
// Moving-average filter on raw MPU temperature, scaled to centi-degrees C, with hysteretic over-temp alarm.
// Latency: o_temp_valid exactly 3 clks after the accepting i_sample_valid cycle; one sample per clock.
// Backpressure: none, samples are never stalled. Define MPU_TEMP_MINMAX_EN to add running min/max outputs.
module mpu_temp_filter #(
   parameter int AVG_LOG2        = 3,
   parameter int TEMP_OFFSET     = 0,
   parameter int SCALE_Q16       = 19629,
   parameter int BASE_CDEG       = 2100,
   parameter int ALARM_HI_CDEG   = 6000,
   parameter int ALARM_HYST_CDEG = 200
) (
   input  logic        i_Clk,
   input  logic        i_Rst_L,
   input  logic        i_sample_valid,
   input  logic [15:0] i_sample,
   input  logic        i_filter_clr,
`ifdef MPU_TEMP_MINMAX_EN
   input  logic        i_minmax_clr,
   output logic [15:0] o_temp_min,
   output logic [15:0] o_temp_max,
`endif
   output logic        o_temp_valid,
   output logic [15:0] o_temp_cdeg,
   output logic        o_over_temp,
   output logic        o_warm
);

   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = 16 + AVG_LOG2;
   localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2 + 1)'(N);
   localparam logic [AVG_LOG2:0]   FILL_WARM = (AVG_LOG2 + 1)'(N - 1);
   localparam logic signed [16:0]  SCALE_S   = 17'(SCALE_Q16);
   localparam logic signed [16:0]  OFFS_S    = 17'(TEMP_OFFSET);
   localparam int                  CLR_CDEG  = ALARM_HI_CDEG - ALARM_HYST_CDEG;

   logic signed [15:0]   sample_buf [N];
   logic signed [SW-1:0] sum_q;
   logic [AVG_LOG2-1:0]  wptr_q;
   logic [AVG_LOG2:0]    fill_q;
   logic                 v1_q;
   logic                 v2_q;
   logic signed [33:0]   prod_q;

   logic signed [SW-1:0] samp_ext;
   logic signed [SW-1:0] old_ext;
   logic signed [15:0]   avg;
   logic signed [16:0]   diff;
   logic signed [31:0]   t_wide;
   logic signed [15:0]   t_sat;
   logic                 out_fire;

   assign samp_ext = {{AVG_LOG2{i_sample[15]}}, i_sample};
   assign old_ext  = {{AVG_LOG2{sample_buf[wptr_q][15]}}, sample_buf[wptr_q]};

   // Stage 0: circular buffer and running sum; clear has priority over a coincident sample.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         for (int i = 0; i < N; i++) sample_buf[i] <= '0;
         sum_q  <= '0;
         wptr_q <= '0;
         fill_q <= '0;
         v1_q   <= 1'b0;
      end else if (i_filter_clr) begin
         for (int i = 0; i < N; i++) sample_buf[i] <= '0;
         sum_q  <= '0;
         wptr_q <= '0;
         fill_q <= '0;
         v1_q   <= 1'b0;
      end else if (i_sample_valid) begin
         sample_buf[wptr_q] <= i_sample;
         sum_q  <= sum_q + samp_ext - old_ext;
         wptr_q <= wptr_q + AVG_LOG2'(1);
         if (fill_q != FILL_FULL) fill_q <= fill_q + (AVG_LOG2 + 1)'(1);
         v1_q   <= (fill_q >= FILL_WARM);
      end else begin
         v1_q   <= 1'b0;
      end
   end

   assign o_warm = (fill_q == FILL_FULL);

   // Stage 1 is combinational: floor average and offset removal feed the multiplier directly.
   assign avg  = 16'(sum_q >>> AVG_LOG2);
   assign diff = 17'(avg) - OFFS_S;

   assign t_wide   = 32'(prod_q >>> 16) + BASE_CDEG;
   assign out_fire = v2_q && !i_filter_clr;

   always_comb begin
      t_sat = t_wide[15:0];
      if (t_wide > 32'sd32767)       t_sat = 16'sh7fff;
      else if (t_wide < -32'sd32768) t_sat = 16'sh8000;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         v2_q         <= 1'b0;
         prod_q       <= '0;
         o_temp_valid <= 1'b0;
         o_temp_cdeg  <= '0;
         o_over_temp  <= 1'b0;
      end else begin
         v2_q         <= v1_q && !i_filter_clr;
         prod_q       <= diff * SCALE_S;
         o_temp_valid <= out_fire;
         if (out_fire) begin
            o_temp_cdeg <= t_sat;
            if (t_sat >= ALARM_HI_CDEG)  o_over_temp <= 1'b1;
            else if (t_sat < CLR_CDEG)   o_over_temp <= 1'b0;
         end
      end
   end

`ifdef MPU_TEMP_MINMAX_EN
   logic mm_loaded_q;

   // First result after any clear seeds both extremes.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_temp_min  <= '0;
         o_temp_max  <= '0;
         mm_loaded_q <= 1'b0;
      end else if (i_minmax_clr) begin
         o_temp_min  <= '0;
         o_temp_max  <= '0;
         mm_loaded_q <= 1'b0;
      end else if (i_filter_clr) begin
         mm_loaded_q <= 1'b0;
      end else if (v2_q) begin
         if (!mm_loaded_q || (t_sat < $signed(o_temp_min))) o_temp_min <= t_sat;
         if (!mm_loaded_q || (t_sat > $signed(o_temp_max))) o_temp_max <= t_sat;
         mm_loaded_q <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/mpu_temp_filter.md
Name: mpu_temp_filter

Overview:
- Downstream consumer of the MPU temperature SPI controller's raw sample stream (signed 16-bit TEMP_OUT value plus a 1-clk new-sample strobe).
- Smooths the raw samples with a power-of-two moving-average filter and converts the result to signed centi-degrees Celsius in fixed point.
- Generates an over-temperature flag with hysteresis. Output feeds display/LED and alarm logic.

Parameters:
- AVG_LOG2, 3, log2 of averaging window depth N (N = 2^AVG_LOG2); legal range 1..6.
- TEMP_OFFSET, 0, raw room-temperature offset subtracted before scaling (signed 16-bit).
- SCALE_Q16, 19629, LSB-to-centidegree gain in Q0.16 (100/333.87 * 65536).
- BASE_CDEG, 2100, centidegree offset added after scaling (21.00 C).
- ALARM_HI_CDEG, 6000, alarm set threshold (signed 16-bit).
- ALARM_HYST_CDEG, 200, alarm clear hysteresis (non-negative).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  reset; asynchronous assert, active-low.
- i_sample_valid  in  1  1-clk strobe: i_sample is valid this cycle.
- i_sample  in  16  raw signed temperature from the SPI controller.
- i_filter_clr  in  1  synchronous clear of filter state.
- o_temp_valid  out  1  1-clk strobe: o_temp_cdeg and o_over_temp updated.
- o_temp_cdeg  out  16  signed filtered temperature, 0.01 C/LSB.
- o_over_temp  out  1  over-temperature flag, hysteretic.
- o_warm  out  1  high once N samples have been accepted since reset/clear.

Behaviour:
- Reset (i_Rst_L low, asynchronous):
  - All buffer entries, running sum, write pointer, fill counter and pipeline valids are 0.
  - All outputs are 0.
- Storage:
  - Circular buffer of N signed 16-bit entries.
  - Running sum of width 16+AVG_LOG2, signed.
  - Write pointer of width AVG_LOG2; wraps N-1 -> 0.
- Stage 0, cycle of i_sample_valid:
  - sum <= sum + sample - buf[wptr]; buf[wptr] <= sample; wptr++.
  - Fill counter increments, saturating at N; o_warm goes high in the cycle after the Nth acceptance.
- Stage 1: avg = sum >>> AVG_LOG2 (arithmetic, floor); d = avg - TEMP_OFFSET, 17-bit signed.
- Stage 2: p = d * SCALE_Q16, 34-bit signed product, registered.
- Stage 3:
  - t = (p >>> 16) + BASE_CDEG, arithmetic shift (floor).
  - t saturates to [-32768, 32767] and is registered to o_temp_cdeg.
  - o_temp_valid pulses 1 clk.
- Latency and throughput:
  - o_temp_valid asserts exactly 3 clks after the accepting i_sample_valid cycle.
  - Fully pipelined: back-to-back valids every cycle are accepted, and each produces one output.
- Warm-up:
  - Output valids are suppressed for samples accepted while fill count < N-1 before acceptance.
  - The Nth sample is the first to produce o_temp_valid.
  - o_temp_cdeg holds its last value between valids.
- Alarm, evaluated on the new t in the same cycle o_temp_valid asserts:
  - Set when t >= ALARM_HI_CDEG.
  - Clear when t < ALARM_HI_CDEG - ALARM_HYST_CDEG.
  - Otherwise hold.
- i_filter_clr:
  - Zeroes buffer, sum, wptr, fill counter, o_warm and all in-flight stage valids in one cycle; in-flight results are dropped.
  - o_temp_cdeg and o_over_temp hold their values.
  - If asserted together with i_sample_valid, clear wins and the sample is discarded.
- Reset mid-pipeline discards everything; no spurious o_temp_valid after reset release.

Optional Feature:
- Macro MPU_TEMP_MINMAX_EN.
- Defined:
  - Adds input i_minmax_clr (1) and outputs o_temp_min (16) and o_temp_max (16).
  - On each o_temp_valid, min/max are updated with t.
  - The first valid after reset, i_filter_clr or i_minmax_clr loads both min and max with t.
  - i_minmax_clr is synchronous and clears both to 0 until the next valid.
  - Both outputs reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 8 samples of 0 spaced 5 clks (defaults) -> no o_temp_valid for samples 1-7; o_temp_valid 3 clks after the 8th; o_temp_cdeg=2100, o_over_temp=0, o_warm=1.
- 8 samples alternating 0 and 6678, back-to-back every cycle -> avg 3339, o_temp_cdeg=3100; after the 8th sample, one valid per cycle.
- 8 samples of -3339 -> o_temp_cdeg=1099 (floor rounding check).
- Alarm sweep, 8 samples at each level:
  - 8x13356 -> o_temp_cdeg=6100, alarm sets.
  - 8x12688 -> 5900, alarm stays set.
  - 8x12300 -> 5784, alarm clears.
- i_filter_clr asserted with i_sample_valid while 2 results are in flight -> no further o_temp_valid; o_warm=0; 8 new samples are required before the next valid.
- With MPU_TEMP_MINMAX_EN: feed 8x0, 8x3339, 8x-3339 -> o_temp_min=1099, o_temp_max=3100; pulse i_minmax_clr -> both 0.
